rsc_encoder: RTL and testbench

Recursive systematic convolutional (RSC) encoder that produces the systematic and parity bit streams consumed by the MAP decoder's channel and branch-metric stages. It encodes one frame of FRAME_LEN information bits and then appends MEM trellis-termination tail bits, which drive the encoder back to state zero. The memory cells are a MEM-deep shift register. Input uses a valid/ready handshake; output uses a registered valid/ready handshake with backpressure.

---
 rtl/rsc_pkg.sv | 27 ++
 rtl/rsc_trellis_step.sv | 48 ++++
 rtl/rsc_encoder.sv | 175 +++++++++++++++++
 tb/tb_rsc_encoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsc_pkg.sv
// rsc_pkg
// Shared definitions for the RSC encoder slice:
//   - rsc_state_e : encoder FSM states (IDLE, ENCODE, TERM)
//   - G_FB_DEF    : default feedback generator (bit 0 = input tap, bit i taps s_i)
//   - G_FF_DEF    : default feedforward generator (bit 0 taps a, bit i taps s_i)
//   - clog2()     : counter width helper, never returns less than 1
package rsc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    TERM   = 2'd2
  } rsc_state_e;

  localparam logic [2:0] G_FB_DEF = 3'b111;
  localparam logic [2:0] G_FF_DEF = 3'b101;

  // Bits needed to hold values 0..value-1; a single bit at minimum so
  // degenerate sizes still give a legal vector.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// rsc_trellis_step
// One combinational step of the recursive systematic convolutional trellis.
// Shared between the encoder and the branch-metric unit, which enumerates
// trellis transitions with it.
//
// Ports:
//   u_sel      in   0: encoder input is in_bit, 1: termination (tail) input
//   in_bit     in   information bit used when u_sel = 0
//   state      in   MEM memory cells, state[i-1] holds s_i (s_1 most recent)
//   a          out  recursive feedback value shifted into s_1
//   p          out  parity bit
//   tail_u     out  input bit that forces a = 0 (termination input)
//   next_state out  state after the step
module rsc_trellis_step
  import rsc_pkg::*;
#(
  parameter int             MEM  = 2,
  parameter logic [MEM:0]   G_FB = G_FB_DEF,
  parameter logic [MEM:0]   G_FF = G_FF_DEF
) (
  input  logic           u_sel,
  input  logic           in_bit,
  input  logic [MEM-1:0] state,
  output logic           a,
  output logic           p,
  output logic           tail_u,
  output logic [MEM-1:0] next_state
);

  logic fb;
  logic u;

  // The feedback sum over the memory cells doubles as the tail input:
  // feeding it back in cancels itself, so a = 0 and the register drains.
  always_comb begin
    fb     = ^(G_FB[MEM:1] & state);
    tail_u = fb;
    u      = u_sel ? fb : in_bit;
    a      = u ^ fb;
    p      = (G_FF[0] & a) ^ (^(G_FF[MEM:1] & state));
    next_state    = '0;
    next_state[0] = a;
    for (int i = 1; i < MEM; i++) begin
      next_state[i] = state[i-1];
    end
  end

endmodule

// File: rtl/rsc_encoder.sv
// rsc_encoder
// Recursive systematic convolutional encoder. Encodes FRAME_LEN information
// bits, then appends MEM termination bits that return the trellis to state 0.
// Input is a valid/ready handshake; output is a registered valid/ready stage
// that can load a new symbol in the same cycle the old one is taken.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse, begins a frame (only honoured in IDLE)
//   in_valid/in_ready/in_bit       information bit handshake
//   out_valid/out_ready            output symbol handshake
//   out_sys        systematic bit (tail input bit during termination)
//   out_par        parity bit
//   out_tail       symbol is a termination bit
//   out_last       final tail symbol of the frame
//   out_par_valid  only with RSC_PUNCTURE_EN defined: parity kept after
//                  rate-1/2 puncturing (even info symbols and all tails)
//   busy           FSM is not IDLE
//
// Optional build macro: RSC_PUNCTURE_EN adds out_par_valid.
module rsc_encoder
  import rsc_pkg::*;
#(
  parameter int           FRAME_LEN = 16,
  parameter int           MEM       = 2,
  parameter logic [MEM:0] G_FB      = G_FB_DEF,
  parameter logic [MEM:0] G_FF      = G_FF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_par,
  output logic out_tail,
  output logic out_last,
`ifdef RSC_PUNCTURE_EN
  output logic out_par_valid,
`endif
  output logic busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ENCODE = ENCODE;
  localparam logic [1:0] S_TERM   = TERM;

  // One counter serves both the information and the tail phase.
  localparam int CNT_W = clog2(((FRAME_LEN > MEM) ? FRAME_LEN : MEM) + 1);
  localparam logic [CNT_W-1:0] INFO_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(MEM - 1);

  logic [1:0]       state;
  logic [MEM-1:0]   sreg;
  logic [CNT_W-1:0] cnt;

  logic             free;
  logic             in_term;
  logic             step_en;
  logic             sym_u;
  logic             step_a;
  logic             step_p;
  logic             step_tail_u;
  logic [MEM-1:0]   step_next;
  logic             unused_step_a;

  rsc_trellis_step #(
    .MEM  (MEM),
    .G_FB (G_FB),
    .G_FF (G_FF)
  ) u_step (
    .u_sel      (in_term),
    .in_bit     (in_bit),
    .state      (sreg),
    .a          (step_a),
    .p          (step_p),
    .tail_u     (step_tail_u),
    .next_state (step_next)
  );

  // step_a is already folded into step_next; the port exists for the
  // branch-metric unit, which reuses the step.
  assign unused_step_a = step_a;

  // The output slot is free when empty or being drained this cycle; every
  // trellis advance waits on it, which is how backpressure stalls the FSM.
  assign free     = !out_valid || out_ready;
  assign in_term  = (state == S_TERM);
  assign in_ready = (state == S_ENCODE) && free;
  assign step_en  = free && (((state == S_ENCODE) && in_valid) || in_term);
  assign sym_u    = in_term ? step_tail_u : in_bit;
  assign busy     = (state != S_IDLE);

  // Control path: frame FSM, bit/tail counter and the encoder memory.
  // IDLE keeps the memory and counter cleared so every frame starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sreg <= '0;
          cnt  <= '0;
          if (start) state <= S_ENCODE;
        end
        S_ENCODE: begin
          if (step_en) begin
            sreg <= step_next;
            if (cnt == INFO_LAST) begin
              cnt   <= '0;
              state <= S_TERM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_TERM: begin
          if (step_en) begin
            if (cnt == TAIL_LAST) begin
              sreg  <= '0;
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              sreg <= step_next;
              cnt  <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          sreg  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: loads whenever the trellis steps, otherwise empties
  // once the consumer takes the symbol; fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_par   <= 1'b0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
    end else if (step_en) begin
      out_valid <= 1'b1;
      out_sys   <= sym_u;
      out_par   <= step_p;
      out_tail  <= in_term;
      out_last  <= in_term && (cnt == TAIL_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RSC_PUNCTURE_EN
  // Puncturing keeps parity on even-indexed information symbols and on
  // every tail symbol; the info index is the counter value at the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par_valid <= 1'b0;
    end else if (step_en) begin
      out_par_valid <= in_term || !cnt[0];
    end
  end
`endif

endmodule

// File: tb/tb_rsc_encoder.sv
// tb_rsc_encoder
// Randomised bench for rsc_encoder (FRAME_LEN=8, MEM=2). A frame-level
// difference-equation model produces the expected symbol stream, which a
// negedge monitor compares symbol by symbol; stalled symbols must hold.
// Build with RSC_PUNCTURE_EN to also check out_par_valid.
module tb_rsc_encoder;

  localparam int           FL  = 8;
  localparam int           MEM = 2;
  localparam logic [MEM:0] GFB = 3'b111;
  localparam logic [MEM:0] GFF = 3'b101;

  typedef struct packed {
    logic sys;
    logic par;
    logic tail;
    logic last;
    logic pv;
  } sym_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, in_bit;
  logic out_valid, out_ready, out_sys, out_par, out_tail, out_last, busy;
`ifdef RSC_PUNCTURE_EN
  logic out_par_valid;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  sym_t sb_q[$];
  sym_t mdl_q[$];
  sym_t held;
  bit   held_v = 1'b0;
  int   sym_idx = 0;

  always #5 clk = ~clk;

  rsc_encoder #(
    .FRAME_LEN (FL),
    .MEM       (MEM),
    .G_FB      (GFB),
    .G_FF      (GFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sys   (out_sys),
    .out_par   (out_par),
    .out_tail  (out_tail),
    .out_last  (out_last),
`ifdef RSC_PUNCTURE_EN
    .out_par_valid (out_par_valid),
`endif
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Time-series model: a[k] = u[k] ^ sum G_FB[i]*a[k-i], p[k] = sum G_FF[i]*a[k-i].
  // Tail inputs are chosen so that a[k] = 0.
  function automatic void model_frame(input logic [15:0] bits, input int n);
    logic av [0:31];
    logic fb, u, p;
    sym_t s;
    mdl_q.delete();
    for (int k = 0; k < n + MEM; k++) begin
      fb = 1'b0;
      for (int i = 1; i <= MEM; i++) if (k >= i) fb ^= GFB[i] & av[k-i];
      u     = (k < n) ? bits[k] : fb;
      av[k] = u ^ fb;
      p     = GFF[0] & av[k];
      for (int i = 1; i <= MEM; i++) if (k >= i) p ^= GFF[i] & av[k-i];
      s.sys  = u;
      s.par  = p;
      s.tail = (k >= n);
      s.last = (k == n + MEM - 1);
`ifdef RSC_PUNCTURE_EN
      s.pv   = (k >= n) || (k % 2 == 0);
`else
      s.pv   = 1'b1;
`endif
      mdl_q.push_back(s);
    end
  endfunction

  function automatic sym_t dut_sym();
    sym_t s;
    s.sys  = out_sys;
    s.par  = out_par;
    s.tail = out_tail;
    s.last = out_last;
`ifdef RSC_PUNCTURE_EN
    s.pv   = out_par_valid;
`else
    s.pv   = 1'b1;
`endif
    return s;
  endfunction

  // Pin the model with hand-derived sequences (bit k = symbol k).
  task automatic pinModel();
    logic [15:0] v_sys, v_par, v_tail, v_last, v_pv;
    model_frame(16'b0001, 4);
    v_sys = '0; v_par = '0; v_tail = '0; v_last = '0; v_pv = '0;
    foreach (mdl_q[k]) begin
      v_sys[k] = mdl_q[k].sys; v_par[k] = mdl_q[k].par;
      v_tail[k] = mdl_q[k].tail; v_last[k] = mdl_q[k].last; v_pv[k] = mdl_q[k].pv;
    end
    checkOutput("model4_par", v_par, 16'b100111);
    checkOutput("model4_sys", v_sys, 16'b110001);
    checkOutput("model4_tail", v_tail, 16'b110000);
    checkOutput("model4_last", v_last, 16'b100000);
`ifdef RSC_PUNCTURE_EN
    checkOutput("model4_pv", v_pv, 16'b110101);
`else
    checkOutput("model4_pv", v_pv, 16'b111111);
`endif
    model_frame(16'b0000_0001, 8);
    v_sys = '0; v_par = '0;
    foreach (mdl_q[k]) begin
      v_sys[k] = mdl_q[k].sys; v_par[k] = mdl_q[k].par;
    end
    checkOutput("model8_par", v_par, 16'b11_1011_0111);
    checkOutput("model8_sys", v_sys, 16'b10_0000_0001);
    mdl_q.delete();
  endtask

  // Consumer-side monitor: every taken symbol must be the next expected
  // one, and a stalled symbol must not change until it is taken.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) checkOutput("stall_hold", {11'b0, dut_sym()}, {11'b0, held});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL extra_symbol: got %0h, expected none", dut_sym());
        end else begin
          checkOutput($sformatf("symbol_%0d", sym_idx), {11'b0, dut_sym()}, {11'b0, sb_q.pop_front()});
        end
        sym_idx++;
        held_v = 1'b0;
      end else if (out_valid) begin
        held   = dut_sym();
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // One frame: start pulse, FL bits with optional random gaps and output
  // backpressure, optional stray start pulses while busy, wait for IDLE.
  task automatic applyStimulus(input logic [FL-1:0] bits, input bit rnd, input bit stray);
    int idx;
    int cyc;
    model_frame(16'(bits), FL);
    foreach (mdl_q[k]) sb_q.push_back(mdl_q[k]);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < FL && cyc < 400) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit    = bits[idx];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = stray && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("frame_bits_accepted", 16'(idx), 16'(FL));
    in_valid = 1'b0;
    start    = stray;
    cyc = 0;
    while (busy && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    checkOutput("frame_done_busy", {15'b0, busy}, 16'd0);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((sb_q.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drain_pending", 16'(sb_q.size()), 16'd0);
  endtask

  initial begin
    logic [FL-1:0] rb;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    pinModel();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("reset_busy", {15'b0, busy}, 16'd0);
    checkOutput("reset_in_ready", {15'b0, in_ready}, 16'd0);
    checkOutput("reset_fields", {12'b0, out_sys, out_par, out_tail, out_last}, 16'd0);

    // Impulse at full throughput, then a known pattern.
    applyStimulus(8'b0000_0001, 1'b0, 1'b0);
    applyStimulus(8'b1011_0010, 1'b0, 1'b1);
    drain();

    // Random frames back to back with backpressure and stray starts.
    for (int f = 0; f < 8; f++) begin
      rb = FL'($urandom());
      applyStimulus(rb, 1'b1, f[0]);
    end
    drain();

    // Reset three bits into a frame: output dropped, encoder idle.
    rb = FL'($urandom());
    model_frame(16'(rb), FL);
    foreach (mdl_q[k]) sb_q.push_back(mdl_q[k]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_bit = rb[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("midreset_busy", {15'b0, busy}, 16'd0);
    checkOutput("midreset_in_ready", {15'b0, in_ready}, 16'd0);
    rst = 1'b0;
    sb_q.delete();

    // Frames after the abort must encode from a clean state.
    applyStimulus(8'b0000_0001, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      rb = FL'($urandom());
      applyStimulus(rb, 1'b1, 1'b1);
    end
    drain();
    checkOutput("final_busy", {15'b0, busy}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
